// File: rtl/pe_row_deskew.sv
// Realigns diagonally skewed PE-column results into full rows and counts them against a job length.
// Optional skew detection is built in when PE_ROW_DESKEW_SKEW_CHECK_EN is defined.
module pe_row_deskew #(
  parameter int NUM   = 4,
  parameter int DW    = 32,
  parameter int ROW_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ROW_W-1:0]             cfg_rows,
  input  logic [3:0]                   cfg_func,
  input  logic [NUM-1:0]               in_valid,
  input  logic signed [NUM-1:0][DW-1:0] in,
  output logic signed [NUM-1:0][DW-1:0] out,
  output logic                         out_en,
  output logic [3:0]                   func,
  output logic                         busy,
  output logic                         done,
  output logic                         skew_err
);

  logic [NUM-1:0]          v_al;
  logic [NUM-1:0][DW-1:0]  d_al;
  logic                    all_v;
  logic [ROW_W-1:0]        cnt;
  logic [ROW_W-1:0]        rows_q;
  logic [ROW_W-1:0]        cnt_inc;

  // Lane i is delayed NUM-1-i cycles so every lane's tail lines up with lane NUM-1.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    localparam int D = NUM - 1 - i;
    if (D == 0) begin : g_pass
      assign v_al[i] = in_valid[i];
      assign d_al[i] = in[i];
    end else begin : g_dly
      logic [D-1:0]  vs;
      logic [DW-1:0] ds [D];

      // NOTE: sequential state is updated with non-blocking assignments so every stage samples its predecessor's pre-edge value.
      always_ff @(posedge clk) begin
        if (!reset) begin
          vs <= '0;
        end else begin
          vs[0] <= in_valid[i];
          for (int k = 1; k < D; k++) vs[k] <= vs[k-1];
        end
      end

      // NOTE: data stages carry no reset; the valid bits alone decide what is meaningful.
      always_ff @(posedge clk) begin
        ds[0] <= in[i];
        for (int k = 1; k < D; k++) ds[k] <= ds[k-1];
      end

      assign v_al[i] = vs[D-1];
      assign d_al[i] = ds[D-1];
    end
  end

  assign all_v   = &v_al;
  assign cnt_inc = cnt + 1'b1;

`ifdef PE_ROW_DESKEW_SKEW_CHECK_EN
  logic any_v;
  assign any_v = |v_al;
`else
  assign skew_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out    <= '0;
      out_en <= 1'b0;
      func   <= 4'h0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      rows_q <= '0;
`ifdef PE_ROW_DESKEW_SKEW_CHECK_EN
      skew_err <= 1'b0;
`endif
    end else begin
      out_en <= 1'b0;
      done   <= 1'b0;
      if (start && !busy) begin
        func   <= cfg_func;
        rows_q <= cfg_rows;
        cnt    <= '0;
        busy   <= (cfg_rows != '0);
        done   <= (cfg_rows == '0);
`ifdef PE_ROW_DESKEW_SKEW_CHECK_EN
        skew_err <= 1'b0;
`endif
      end else if (busy) begin
        // Partial rows fall through untouched: never emitted, never counted.
        if (all_v) begin
          out    <= d_al;
          out_en <= 1'b1;
          cnt    <= cnt_inc;
          if (cnt_inc == rows_q) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
`ifdef PE_ROW_DESKEW_SKEW_CHECK_EN
        else if (any_v) begin
          skew_err <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pe_row_deskew.sv
// Self-checking bench for pe_row_deskew: directed scenarios plus random jobs against a cycle-indexed reference model.
// Expected skew_err follows PE_ROW_DESKEW_SKEW_CHECK_EN.
module tb_pe_row_deskew;
  localparam int NUM   = 4;
  localparam int DW    = 32;
  localparam int ROW_W = 16;
  localparam int MAXC  = 1024;
`ifdef PE_ROW_DESKEW_SKEW_CHECK_EN
  localparam bit SKEW_EN = 1'b1;
`else
  localparam bit SKEW_EN = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic [ROW_W-1:0]       cfg_rows;
  logic [3:0]             cfg_func;
  logic [NUM-1:0]         in_valid;
  logic [NUM-1:0][DW-1:0] din;
  logic [NUM-1:0][DW-1:0] dout;
  logic                   out_en;
  logic [3:0]             func;
  logic                   busy;
  logic                   done;
  logic                   skew_err;

  pe_row_deskew #(.NUM(NUM), .DW(DW), .ROW_W(ROW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows), .cfg_func(cfg_func),
    .in_valid(in_valid), .in(din), .out(dout), .out_en(out_en), .func(func),
    .busy(busy), .done(done), .skew_err(skew_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input schedule indexed by cycle; it doubles as the history the model aligns from.
  logic [NUM-1:0]         sv [MAXC];
  logic [NUM-1:0][DW-1:0] sd [MAXC];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rst = -1;
  int n_en, en_first, en_last, done_cyc;

  // Reference model state
  logic [NUM-1:0][DW-1:0] m_out;
  bit m_en, m_busy, m_done, m_skew;
  logic [3:0] m_func;
  int m_cnt, m_rows;

  task automatic check(string tag, logic [NUM*DW-1:0] obs, logic [NUM*DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic put_row(int t0, int late_lane, logic [NUM-1:0][DW-1:0] v);
    for (int i = 0; i < NUM; i++) begin
      int t;
      t = t0 + i + ((i == late_lane) ? 1 : 0);
      if (t < MAXC) begin
        sv[t][i] = 1'b1;
        sd[t][i] = v[i];
      end
    end
  endtask

  // Lane i seen at the output register on the edge closing cycle c comes from cycle c-(NUM-1-i),
  // provided no reset occurred since then.
  task automatic model_edge();
    logic [NUM-1:0][DW-1:0] row;
    int nv;
    if (!reset) begin
      m_out = '0; m_en = 0; m_func = 4'h0; m_busy = 0; m_done = 0; m_skew = 0;
      m_cnt = 0; m_rows = 0; last_rst = cyc;
    end else begin
      nv = 0;
      row = '0;
      for (int i = 0; i < NUM; i++) begin
        int s;
        s = cyc - (NUM - 1 - i);
        if (s >= 0 && s > last_rst && sv[s][i]) begin
          nv++;
          row[i] = sd[s][i];
        end
      end
      m_en = 0;
      m_done = 0;
      if (start && !m_busy) begin
        m_func = cfg_func;
        m_rows = int'(cfg_rows);
        m_cnt  = 0;
        m_skew = 0;
        m_busy = (cfg_rows != 0);
        m_done = (cfg_rows == 0);
      end else if (m_busy) begin
        if (nv == NUM) begin
          m_out = row;
          m_en  = 1;
          m_cnt = (m_cnt + 1) % (1 << ROW_W);
          if (m_cnt == m_rows) begin
            m_busy = 0;
            m_done = 1;
          end
        end else if (nv != 0 && SKEW_EN) begin
          m_skew = 1;
        end
      end
    end
  endtask

  task automatic step();
    in_valid = sv[cyc];
    for (int i = 0; i < NUM; i++) din[i] = sv[cyc][i] ? sd[cyc][i] : DW'($urandom);
    @(posedge clk);
    #1;
    model_edge();
    check("out", dout, m_out);
    check("out_en", out_en, m_en);
    check("func", func, m_func);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("skew_err", skew_err, m_skew);
    if (out_en === 1'b1) begin
      n_en++;
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if (done === 1'b1) done_cyc = cyc;
    cyc++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_stats();
    n_en = 0; en_first = -1; en_last = -1; done_cyc = -1;
  endtask

  initial begin
    logic [NUM-1:0][DW-1:0] v;
    logic [NUM-1:0][DW-1:0] exp_row;
    logic [3:0] f_keep;
    int t;

    for (int c = 0; c < MAXC; c++) begin
      sv[c] = '0;
      sd[c] = '0;
    end
    reset = 1'b0; start = 1'b0; cfg_rows = '0; cfg_func = 4'h0;
    in_valid = '0; din = '0;
    clr_stats();

    // Reset for two cycles
    run(2);
    check("rst_out", dout, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_func", func, 4'h0);
    reset = 1'b1;
    run(2);

    // Basic job: three spaced rows {10+r,20+r,30+r,40+r}
    cfg_rows = 16'd3; cfg_func = 4'h2;
    t = cyc;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM; i++) v[i] = DW'((i + 1) * 10 + r);
      put_row(t + 1 + 2 * r, -1, v);
    end
    clr_stats();
    start = 1'b1; step(); start = 1'b0;
    run(12);
    for (int i = 0; i < NUM; i++) exp_row[i] = DW'((i + 1) * 10 + 2);
    check("basic_n_en", n_en, 3);
    check("basic_lat", en_first, t + 4);
    check("basic_last", dout, exp_row);
    check("basic_done_coinc", done_cyc, en_last);
    check("basic_func", func, 4'h2);

    // Back-to-back rows, rows=5, sixth row dropped; a second start while busy is ignored
    cfg_rows = 16'd5; cfg_func = 4'($urandom_range(1, 15));
    f_keep = cfg_func;
    t = cyc;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM; i++) v[i] = DW'($urandom);
      put_row(t + 1 + r, -1, v);
    end
    clr_stats();
    start = 1'b1; step(); start = 1'b0;
    cfg_rows = 16'd9; cfg_func = 4'h7;
    run(2);
    start = 1'b1; step(); start = 1'b0;
    run(12);
    check("b2b_n_en", n_en, 5);
    check("b2b_consecutive", en_last - en_first, 4);
    check("b2b_func_held", func, f_keep);
    check("b2b_idle", busy, 1'b0);

    // Zero-row job
    cfg_rows = 16'd0; cfg_func = 4'h3;
    start = 1'b1; step(); start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    step();
    check("zero_done_off", done, 1'b0);
    check("zero_busy_off", busy, 1'b0);

    // Skew: lane 2 late on the first row of a two-row job
    cfg_rows = 16'd2; cfg_func = 4'h5;
    t = cyc;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM; i++) v[i] = DW'($urandom);
      put_row(t + 1 + 4 * r, (r == 0) ? 2 : -1, v);
    end
    clr_stats();
    start = 1'b1; step(); start = 1'b0;
    run(6);
    check("skew_busy_held", busy, 1'b1);
    check("skew_flag", skew_err, SKEW_EN);
    run(10);
    check("skew_n_en", n_en, 2);
    check("skew_sticky", skew_err, SKEW_EN);
    check("skew_idle", busy, 1'b0);

    // Reset mid-job discards in-flight rows
    cfg_rows = 16'd4; cfg_func = 4'h6;
    t = cyc;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM; i++) v[i] = DW'($urandom);
      put_row(t + 1 + r, -1, v);
    end
    start = 1'b1; step(); start = 1'b0;
    run(2);
    reset = 1'b0; step(); reset = 1'b1;
    clr_stats();
    run(10);
    check("midrst_n_en", n_en, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_func", func, 4'h0);

    // Random jobs with occasional late lanes
    for (int j = 0; j < 5; j++) begin
      int nrows, tt;
      nrows = $urandom_range(1, 6);
      cfg_rows = 16'(nrows);
      cfg_func = 4'($urandom);
      tt = cyc + 1;
      for (int r = 0; r < nrows + 2; r++) begin
        for (int i = 0; i < NUM; i++) v[i] = DW'($urandom);
        put_row(tt, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM - 2) : -1, v);
        tt += $urandom_range(2, 3);
      end
      start = 1'b1; step(); start = 1'b0;
      run(tt - cyc + NUM + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_row_deskew.md
Name: pe_row_deskew

Overview:
- Sits between the systolic PE array's bottom edge and the elementwise post-processing array.
- PE columns emit results diagonally skewed: lane i is valid i cycles after lane 0.
- This block delays each lane so a full NUM-wide row is realigned, then presents it with a one-cycle enable and a held function select.
- Counts rows against a programmed job length and signals completion.

Parameters:
- NUM, 4, number of lanes (PE columns); must be >= 2.
- DW, 32, signed data width per lane.
- ROW_W, 16, width of the row counter and cfg_rows.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a job.
- cfg_rows  input  ROW_W  rows in the job; sampled on an accepted start.
- cfg_func  input  4  elementwise function; sampled on an accepted start.
- in_valid  input  NUM  per-lane valid from PE columns (skewed).
- in  input  NUM x DW signed  per-lane data from PE columns.
- out  output  NUM x DW signed  aligned row to the elementwise array.
- out_en  output  1  one-cycle strobe; out holds a new aligned row.
- func  output  4  held function select for the elementwise array.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse when the job completes.
- skew_err  output  1  sticky misalignment flag.

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - out to all 0, out_en 0, func 0, busy 0, done 0, skew_err 0.
  - Row counter 0, latched rows 0.
  - All delay-line valid bits 0. Delay-line data need not be cleared.
- Delay lines: lane i passes through D_i = NUM-1-i register stages, so lane NUM-1 has zero stages.
  - Each stage carries {valid, data} and shifts every cycle unconditionally.
  - The aligned vector is the tail of each lane: v_al[i], d_al[i].
- Output register:
  - When busy==1 and all v_al are 1: out <= d_al and out_en <= 1 for one cycle; otherwise out_en <= 0.
  - out holds its last value between strobes.
  - Latency: lane i input at cycle t appears on out at edge t + D_i + 1. Lane 0 takes NUM cycles; lane NUM-1 takes 1.
- Start:
  - Accepted only when busy==0; a start while busy is ignored (no state change).
  - On accept: func <= cfg_func, latched rows <= cfg_rows, counter <= 0, skew_err <= 0.
  - If cfg_rows != 0, busy <= 1.
  - If cfg_rows == 0, busy stays 0 and done pulses on the next edge.
- Row counting:
  - Each emitted row increments the counter.
  - When the increment reaches the latched rows, busy <= 0 and done <= 1 on the same edge out_en <= 1 for the final row. done and the final out_en are high in the same cycle.
- Idle rows: aligned rows arriving while busy==0 (before start, or after completion) are dropped. out_en stays 0 and the counter is unchanged.
- Skew check:
  - Applies while busy==1 when v_al is neither all 0 nor all 1.
  - The partial row is dropped: no out_en, not counted.
  - skew_err <= 1 and stays set until the next accepted start or reset.
  - busy is not affected.
- Counter width: compares at ROW_W bits. cfg_rows = 2^ROW_W - 1 is legal.
- Reset mid-job: busy drops and all in-flight valid bits are discarded. Rows already in the delay lines are never emitted.
- func is stable for the whole job and remains held after done until the next accepted start.

Optional Feature:
- Macro: PE_ROW_DESKEW_SKEW_CHECK_EN.
- Defined: the skew check and skew_err behave as above.
- Undefined:
  - skew_err is tied to 0.
  - Partial aligned rows are still dropped silently (no out_en, not counted).
  - No additional logic is generated.

Test Plan:
- NUM=4; reset low 2 cycles -> out all 0, out_en/busy/done/skew_err/func all 0.
- Basic job: start with cfg_rows=3, cfg_func=4'h2; feed 3 rows with lane i at cycles t+i, values {10+r, 20+r, 30+r, 40+r}.
  - out_en pulses 3 times, each row exactly 4 cycles after its lane-0 input.
  - out = {10,20,30,40}, {11,21,31,41}, {12,22,32,42}; func=2 throughout.
  - done is coincident with the third out_en; busy falls on the same edge.
- Back-to-back rows every cycle, cfg_rows=5 -> out_en high for 5 consecutive cycles; a 6th row fed afterwards produces no out_en.
- cfg_rows=0 -> done pulses 1 cycle after start; busy never asserts.
- Second start while busy (cfg_rows=9, cfg_func=7) -> ignored; func and count unchanged.
- Skew error: lane 2 valid delayed by one cycle on row 1 of 2 (macro defined).
  - skew_err=1; that row is not emitted; busy stays 1 until a further full row arrives.
  - Assert reset mid-job -> busy=0 and no out_en for in-flight rows.
  - With the macro undefined -> skew_err stays 0 and the row is still dropped.
